digi_scan_ctrl: RTL and testbench

Scan controller that sits directly upstream of the seven-segment digit decoder. It time-multiplexes the four display digits by stepping a 2-bit digit select at a programmable slot rate, and presents a stable 32-bit display word to the decoder. Software-side writes are buffered and applied only at frame boundaries so a digit sweep never shows mixed old and new values. A blanking window at the start of every slot suppresses ghosting on the shared segment lines.

---
 rtl/digi_scan_ctrl.sv | 93 +++++++++
 tb/tb_digi_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digi_scan_ctrl.sv
// Four-digit scan controller: steps the digit select at a fixed slot rate, blanks the
// start of each slot, and double-buffers the display word so it only changes between frames.
module digi_scan_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] v0_i,
  input  logic        v0_we_i,
  output logic        v0_ack_o,
  output logic [31:0] v0_disp_o,
  output logic [1:0]  ano_o,
  output logic        blank_o,
  output logic        frame_o
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [1:0]     ano_nxt;
  logic           frame_end;
  logic [31:0]    pend;
  logic           pend_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ano_nxt   = ano_o;
    frame_end = 1'b0;
    if (!en_i) begin
      state_nxt = ST_OFF;
    end else begin
      if (state == ST_OFF) begin
        cnt_nxt = '0;
      end else if (cnt == LAST) begin
        cnt_nxt   = '0;
        ano_nxt   = ano_o + 2'd1;
        frame_end = (ano_o == 2'd3);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      // Blank/show phase follows the count the slot will hold next cycle.
      state_nxt = (cnt_nxt < BLANK_END) ? ST_BLANK : ST_SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      ano_o   <= '0;
      blank_o <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ano_o   <= ano_nxt;
      blank_o <= (state_nxt != ST_SHOW);
      frame_o <= frame_end;
    end
  end

  // A write landing on the frame-end cycle is newer than pend, so it goes straight to display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_ack_o   <= 1'b0;
      v0_disp_o  <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      v0_ack_o <= v0_we_i;
      if (frame_end) begin
        if (v0_we_i) begin
          v0_disp_o <= v0_i;
        end else if (pend_valid) begin
          v0_disp_o <= pend;
        end
        pend_valid <= 1'b0;
      end else if (v0_we_i) begin
        pend       <= v0_i;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digi_scan_ctrl.sv
// Bench for digi_scan_ctrl: three parameterisations driven in lockstep and compared
// every cycle against a slot/frame reference model, plus directed scenario checks.
module tb_digi_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic [31:0] v0_i = '0;
  logic        v0_we_i = 1'b0;

  logic        ack   [3];
  logic [31:0] disp  [3];
  logic [1:0]  ano   [3];
  logic        blank [3];
  logic        frame [3];
  logic [36:0] obs   [3];

  int tests = 0;
  int fails = 0;

  localparam logic [36:0] RST = {32'h0, 2'd0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  digi_scan_ctrl #(.DIV(8), .BLANK(2)) u_main (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .v0_i(v0_i), .v0_we_i(v0_we_i),
    .v0_ack_o(ack[0]), .v0_disp_o(disp[0]), .ano_o(ano[0]), .blank_o(blank[0]), .frame_o(frame[0]));
  digi_scan_ctrl #(.DIV(8), .BLANK(0)) u_noblank (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .v0_i(v0_i), .v0_we_i(v0_we_i),
    .v0_ack_o(ack[1]), .v0_disp_o(disp[1]), .ano_o(ano[1]), .blank_o(blank[1]), .frame_o(frame[1]));
  digi_scan_ctrl #(.DIV(2), .BLANK(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .v0_i(v0_i), .v0_we_i(v0_we_i),
    .v0_ack_o(ack[2]), .v0_disp_o(disp[2]), .ano_o(ano[2]), .blank_o(blank[2]), .frame_o(frame[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {disp[g], ano[g], blank[g], frame[g], ack[g]};
  end

  // Reference model: position within slot, digit number, shown word and pending word.
  int          m_div   [3] = '{8, 8, 2};
  int          m_blank [3] = '{2, 0, 1};
  bit          m_run   [3];
  int          m_pos   [3];
  int          m_dig   [3];
  logic [31:0] m_disp  [3];
  logic [31:0] m_pend  [3];
  bit          m_pv    [3];
  bit          m_ack   [3];
  bit          m_frame [3];
  bit          m_blk   [3];

  function automatic logic [36:0] exp_v(int k);
    return {m_disp[k], 2'(m_dig[k]), m_blk[k], m_frame[k], m_ack[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_pos[k] = 0; m_dig[k] = 0; m_disp[k] = '0; m_pend[k] = '0;
      m_pv[k] = 0; m_ack[k] = 0; m_frame[k] = 0; m_blk[k] = 1;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit fe = 0;
      m_ack[k] = v0_we_i;
      if (!en_i) m_run[k] = 0;
      else if (!m_run[k]) begin
        m_run[k] = 1;
        m_pos[k] = 0;
      end else if (m_pos[k] == m_div[k] - 1) begin
        m_pos[k] = 0;
        fe = (m_dig[k] == 3);
        m_dig[k] = (m_dig[k] + 1) % 4;
      end else m_pos[k]++;
      if (fe) begin
        if (v0_we_i) m_disp[k] = v0_i;
        else if (m_pv[k]) m_disp[k] = m_pend[k];
        m_pv[k] = 0;
      end else if (v0_we_i) begin
        m_pend[k] = v0_i;
        m_pv[k] = 1;
      end
      m_frame[k] = fe;
      m_blk[k] = !m_run[k] || (m_pos[k] < m_blank[k]);
    end
  endtask

  task automatic cycle(input logic en, input logic we, input logic [31:0] v);
    en_i = en; v0_we_i = we; v0_i = v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== RST) begin
        fails++; $display("FAIL reset_vals[%0d] got %h want %h", k, obs[k], RST);
      end
    end
    rst_n = 1'b1;
    cycle(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== exp_v(k)) begin
        fails++; $display("FAIL reset_idle[%0d] got %h want %h", k, obs[k], exp_v(k));
      end
    end
  endtask

  task automatic test_free_run();
    int frames = 0;
    int blanks = 0;
    for (int i = 0; i < 72; i++) begin
      cycle(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs[k] !== exp_v(k)) begin
          fails++; $display("FAIL free_run[%0d] t=%0t got %h want %h", k, $time, obs[k], exp_v(k));
        end
      end
      if (i >= 8) begin
        frames += int'(frame[0]);
        blanks += int'(blank[0]);
      end
    end
    tests++;
    if (frames !== 2 || blanks !== 16) begin
      fails++; $display("FAIL free_run_rates frames=%0d blanks=%0d want 2 and 16", frames, blanks);
    end
  endtask

  task automatic test_buffered_write();
    int n = 0;
    bit seen = 0;
    while (!(m_dig[0] == 1 && m_pos[0] == 3) && n < 64) begin cycle(1, 0, 0); n++; end
    cycle(1, 1, 32'h0000_1234);
    tests++;
    if (ack[0] !== 1'b1 || disp[0] !== 32'h0) begin
      fails++; $display("FAIL bw_ack ack=%b disp=%h want 1 and 0", ack[0], disp[0]);
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1, 0, 0);
      tests++;
      if (obs[0] !== exp_v(0)) begin
        fails++; $display("FAIL bw_model got %h want %h", obs[0], exp_v(0));
      end
      if (frame[0]) begin
        seen = 1;
        tests++;
        if (disp[0] !== 32'h0000_1234) begin
          fails++; $display("FAIL bw_apply disp=%h want 00001234", disp[0]);
        end
      end else if (disp[0] !== 32'h0) begin
        tests++; fails++; $display("FAIL bw_early disp=%h want 0", disp[0]);
      end
    end
    tests++;
    if (!seen || n >= 64) begin
      fails++; $display("FAIL bw_timeout seen=%0d wait=%0d", seen, n);
    end
  endtask

  task automatic test_overwrite_collision();
    int n = 0;
    bit seen = 0;
    while (!(m_dig[0] == 0 && m_pos[0] == 1) && n < 64) begin cycle(1, 0, 0); n++; end
    cycle(1, 1, 32'h0000_AAAA);
    cycle(1, 1, 32'h0000_BBBB);
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1, 0, 0);
      if (frame[0]) begin
        seen = 1;
        tests++;
        if (disp[0] !== 32'h0000_BBBB) begin
          fails++; $display("FAIL overwrite disp=%h want 0000bbbb", disp[0]);
        end
      end
    end
    while (!(m_dig[0] == 1 && m_pos[0] == 0) && n < 128) begin cycle(1, 0, 0); n++; end
    cycle(1, 1, 32'h0000_BBBB);
    while (!(m_dig[0] == 3 && m_pos[0] == 7) && n < 192) begin cycle(1, 0, 0); n++; end
    cycle(1, 1, 32'h0000_CCCC);
    tests++;
    if (frame[0] !== 1'b1 || disp[0] !== 32'h0000_CCCC) begin
      fails++; $display("FAIL collision frame=%b disp=%h want 1 and 0000cccc", frame[0], disp[0]);
    end
    for (int i = 0; i < 34; i++) begin
      cycle(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs[k] !== exp_v(k)) begin
          fails++; $display("FAIL collision_model[%0d] got %h want %h", k, obs[k], exp_v(k));
        end
      end
    end
    tests++;
    if (disp[0] !== 32'h0000_CCCC || !seen || n >= 192) begin
      fails++; $display("FAIL collision_hold disp=%h seen=%0d wait=%0d want 0000cccc", disp[0], seen, n);
    end
  endtask

  task automatic test_enable_gating();
    int n = 0;
    bit seen = 0;
    while (!(m_dig[0] == 2 && m_pos[0] == 5) && n < 64) begin cycle(1, 0, 0); n++; end
    for (int i = 0; i < 20; i++) begin
      cycle(0, i == 10, 32'h0000_5A5A);
      tests++;
      if (blank[0] !== 1'b1 || ano[0] !== 2'd2 || obs[0] !== exp_v(0)) begin
        fails++; $display("FAIL gate_off i=%0d got %h want %h", i, obs[0], exp_v(0));
      end
    end
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 0);
      tests++;
      if (ano[0] !== ((i < 8) ? 2'd2 : 2'd3) || blank[0] !== (i < 2 || i == 8)) begin
        fails++; $display("FAIL gate_resume i=%0d ano=%0d blank=%b", i, ano[0], blank[0]);
      end
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1, 0, 0);
      if (frame[0]) begin
        seen = 1;
        tests++;
        if (disp[0] !== 32'h0000_5A5A) begin
          fails++; $display("FAIL gate_write disp=%h want 00005a5a", disp[0]);
        end
      end
    end
    tests++;
    if (!seen || n >= 64) begin
      fails++; $display("FAIL gate_timeout seen=%0d wait=%0d", seen, n);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (!(m_dig[0] == 0 && m_pos[0] == 2) && n < 64) begin cycle(1, 0, 0); n++; end
    cycle(1, 1, 32'hDEAD_BEEF);
    while (!(m_dig[0] == 3 && m_pos[0] == 3) && n < 128) begin cycle(1, 0, 0); n++; end
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== RST) begin
        fails++; $display("FAIL async_reset[%0d] got %h want %h", k, obs[k], RST);
      end
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs[k] !== exp_v(k)) begin
          fails++; $display("FAIL post_reset[%0d] got %h want %h", k, obs[k], exp_v(k));
        end
      end
    end
    tests++;
    if (disp[0] !== 32'h0 || n >= 128) begin
      fails++; $display("FAIL reset_discard disp=%h wait=%0d want 0", disp[0], n);
    end
  endtask

  task automatic test_corner();
    logic [1:0] a0 = ano[2];
    for (int i = 1; i <= 60; i++) begin
      cycle(1, $urandom_range(0, 5) == 0, $urandom);
      tests++;
      if (blank[1] !== 1'b0 || obs[1] !== exp_v(1)) begin
        fails++; $display("FAIL noblank i=%0d got %h want %h", i, obs[1], exp_v(1));
      end
      if (i % 2 == 0) begin
        tests++;
        if (ano[2] !== 2'(a0 + 2'(i / 2)) || obs[2] !== exp_v(2)) begin
          fails++; $display("FAIL div2 i=%0d got %h want %h", i, obs[2], exp_v(2));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs[k] !== exp_v(k)) begin
          fails++; $display("FAIL random[%0d] i=%0d got %h want %h", k, i, obs[k], exp_v(k));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_buffered_write();
    test_overwrite_collision();
    test_enable_gating();
    test_async_reset();
    test_corner();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
